calc_param: RTL and testbench

Parametrised successor of the single-operand-pair decimal calculator. It accepts keypad commands over a valid/ready handshake and accumulates decimal operands of up to `DIGITS` digits. It computes add, subtract or multiply (multiply via a sequential shift-add unit), then serialises the current operand or result one BCD digit per cycle to the display controller. It sits between the keypad decoder and the display-controller block.

---
 rtl/calc_pkg.sv | 38 +++
 rtl/calc_mul.sv | 74 +++++++
 rtl/calc_param.sv | 223 ++++++++++++++++++++++
 tb/tb_calc_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the parametrised decimal calculator.
// Holds the keypad command codes, the status encoding, the FSM states and
// a constant power-of-ten helper used to size the digit and result limits.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_ADD  = 4'd10,
    CMD_SUB  = 4'd11,
    CMD_MUL  = 4'd12,
    CMD_CLR  = 4'd13,
    CMD_EQ   = 4'd14,
    CMD_BKSP = 4'd15
  } cmd_e;

  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_PRINT = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_CALC,
    S_PRINT,
    S_ERROR
  } state_e;

  // 10^n as a 64-bit constant; n never exceeds 15 so no overflow.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/calc_mul.sv
// Sequential shift-add multiplier. A start pulse loads the operands and
// performs the first partial product; the remaining WIDTH-1 partial
// products follow one per cycle, and done pulses with the final product.
module calc_mul #(
  parameter int WIDTH = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  // Next-state: load on start, then one shift-add step per busy cycle.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
      cnt_d    = CNT_W'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Control flops: cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath flops: only meaningful between start and done, so no reset.
  always_ff @(posedge clock) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/calc_param.sv
// Parametrised decimal calculator: keypad commands in over valid/ready,
// operand accumulation, add/sub/mul, and LSD-first BCD serialisation of
// the current operand or result to the display controller.
// Optional feature macro: CALC_CHAIN_EN -- an operator typed while the
// second operand is being entered evaluates the pending operation and
// chains the new operator; without it that operator is an error.
module calc_param
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 27
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 cmd,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [1:0]                 status,
  output logic [3:0]                 data,
  output logic [$clog2(DIGITS)-1:0]  pos,
  output logic                       data_valid
);

  localparam int POS_W = $clog2(DIGITS);
  localparam int RW    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] DIG_LIM = WIDTH'(pow10(DIGITS-1));
  localparam logic [RW-1:0]    RES_LIM = RW'(pow10(DIGITS));

  state_e             state_q, state_d, ret_q, ret_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [3:0]         oper_q, oper_d, nxt_oper_q, nxt_oper_d;
  logic               chain_q, chain_d, fresh_q, fresh_d, run_q, run_d;
  logic [WIDTH-1:0]   print_q, print_d;
  logic [POS_W-1:0]   beat_q, beat_d;

  logic               accept, is_digit, is_op, clr;
  logic [WIDTH-1:0]   op_a_eff;
  logic               mul_start, mul_done, calc_done, calc_err;
  logic [RW-1:0]      product, res;
  status_e            st;

  assign cmd_ready = (state_q == S_ENTER_A) || (state_q == S_ENTER_B) || (state_q == S_ERROR);
  assign accept    = cmd_valid && cmd_ready;
  assign is_digit  = cmd < 4'd10;
  assign is_op     = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
  assign clr       = accept && (cmd == CMD_CLR);
  assign op_a_eff  = fresh_q ? '0 : op_a_q;
  assign mul_start = (state_q == S_CALC) && !run_q && (oper_q == CMD_MUL);

  calc_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a_q),
    .b       (op_b_q),
    .done    (mul_done),
    .product (product)
  );

  // Arithmetic result and its validity for the latched operator.
  always_comb begin
    res = product;
    if (oper_q == CMD_ADD)      res = RW'(op_a_q) + RW'(op_b_q);
    else if (oper_q == CMD_SUB) res = RW'(op_a_q) - RW'(op_b_q);
    calc_done = (oper_q != CMD_MUL) || mul_done;
    calc_err  = ((oper_q == CMD_SUB) && (op_b_q > op_a_q)) || (res >= RES_LIM);
  end

  // Next-state and register updates for the command FSM.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    oper_d     = oper_q;
    nxt_oper_d = nxt_oper_q;
    chain_d    = chain_q;
    fresh_d    = fresh_q;
    print_d    = print_q;
    beat_d     = beat_q;
    run_d      = 1'b0;
    case (state_q)
      S_ENTER_A: if (accept) begin
        if (is_digit) begin
          if (op_a_eff < DIG_LIM) begin
            op_a_d  = op_a_eff * WIDTH'(10) + WIDTH'(cmd);
            fresh_d = 1'b0;
            print_d = op_a_d;
            beat_d  = '0;
            ret_d   = S_ENTER_A;
            state_d = S_PRINT;
          end
        end else if (cmd == CMD_BKSP) begin
          op_a_d  = op_a_q / WIDTH'(10);
          fresh_d = 1'b0;
          print_d = op_a_d;
          beat_d  = '0;
          ret_d   = S_ENTER_A;
          state_d = S_PRINT;
        end else if (is_op) begin
          oper_d  = cmd;
          op_b_d  = '0;
          state_d = S_ENTER_B;
        end
      end
      S_ENTER_B: if (accept) begin
        if (is_digit) begin
          if (op_b_q < DIG_LIM) begin
            op_b_d  = op_b_q * WIDTH'(10) + WIDTH'(cmd);
            print_d = op_b_d;
            beat_d  = '0;
            ret_d   = S_ENTER_B;
            state_d = S_PRINT;
          end
        end else if (cmd == CMD_BKSP) begin
          op_b_d  = op_b_q / WIDTH'(10);
          print_d = op_b_d;
          beat_d  = '0;
          ret_d   = S_ENTER_B;
          state_d = S_PRINT;
        end else if (cmd == CMD_EQ) begin
          chain_d = 1'b0;
          state_d = S_CALC;
        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
          chain_d    = 1'b1;
          nxt_oper_d = cmd;
          state_d    = S_CALC;
`else
          state_d    = S_ERROR;
`endif
        end
      end
      S_CALC: begin
        run_d = 1'b1;
        if (calc_done) begin
          run_d = 1'b0;
          if (calc_err) begin
            state_d = S_ERROR;
          end else begin
            op_a_d  = res[WIDTH-1:0];
            fresh_d = 1'b1;
            print_d = res[WIDTH-1:0];
            beat_d  = '0;
            state_d = S_PRINT;
            if (chain_q) begin
              oper_d = nxt_oper_q;
              op_b_d = '0;
              ret_d  = S_ENTER_B;
            end else begin
              ret_d  = S_ENTER_A;
            end
          end
        end
      end
      S_PRINT: begin
        print_d = print_q / WIDTH'(10);
        beat_d  = beat_q + 1'b1;
        if (beat_q == POS_W'(DIGITS-1)) state_d = ret_q;
      end
      S_ERROR: ;
      default: state_d = S_ENTER_A;
    endcase
    // Clear wins in every command-accepting state, including ERROR.
    if (clr) begin
      op_a_d     = '0;
      op_b_d     = '0;
      oper_d     = '0;
      nxt_oper_d = '0;
      chain_d    = 1'b0;
      fresh_d    = 1'b0;
      print_d    = '0;
      beat_d     = '0;
      ret_d      = S_ENTER_A;
      state_d    = S_PRINT;
    end
  end

  // State and operand registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_ENTER_A;
      ret_q      <= S_ENTER_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      oper_q     <= '0;
      nxt_oper_q <= '0;
      chain_q    <= 1'b0;
      fresh_q    <= 1'b0;
      run_q      <= 1'b0;
      print_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      oper_q     <= oper_d;
      nxt_oper_q <= nxt_oper_d;
      chain_q    <= chain_d;
      fresh_q    <= fresh_d;
      run_q      <= run_d;
      print_q    <= print_d;
      beat_q     <= beat_d;
    end
  end

  // Output decode: status from state, digit stream only while printing.
  always_comb begin
    case (state_q)
      S_CALC:  st = ST_BUSY;
      S_PRINT: st = ST_PRINT;
      S_ERROR: st = ST_ERR;
      default: st = ST_READY;
    endcase
    data_valid = (state_q == S_PRINT);
    pos        = data_valid ? beat_q : '0;
    data       = data_valid ? 4'(print_q % WIDTH'(10)) : 4'd0;
  end

  assign status = st;

endmodule

// File: tb/tb_calc_param.sv
// Self-checking bench for calc_param (DIGITS=8, WIDTH=27): a command table
// with expected prints and status, plus hand-written timing sequences.
module tb_calc_param;

  localparam int DIGITS = 8;
  localparam int WIDTH  = 27;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] status;
  logic [3:0] data;
  logic [2:0] pos;
  logic       data_valid;

  calc_param #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .data_valid (data_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [3:0] d; logic [2:0] p;} beat_t;
  typedef struct {logic [3:0] c; bit pr; longint unsigned val; logic [1:0] st;} vec_t;

  beat_t exp_q[$];
  vec_t  vecs[$];
  beat_t mon_b;
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_val(input longint unsigned v);
    beat_t b;
    longint unsigned p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      b.d = 4'((v / p) % 10);
      b.p = 3'(k);
      exp_q.push_back(b);
      p = p * 10;
    end
  endtask

  task automatic t(input logic [3:0] c, input bit pr, input longint unsigned v, input logic [1:0] st);
    vec_t x;
    x.c = c; x.pr = pr; x.val = v; x.st = st;
    vecs.push_back(x);
  endtask

  task automatic send(input logic [3:0] c);
    int w = 0;
    @(negedge clock);
    while (!cmd_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    repeat (3) @(negedge clock);
    while (!(cmd_ready && exp_q.size() == 0) && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("idle_wait", {63'd0, (w < 200)}, 64'd1);
  endtask

  // Scoreboard: every printed beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en && data_valid) begin
      chk("beat_status", status, 64'd3);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL beat_unexpected: got data %0d pos %0d, required no beat", data, pos);
      end else begin
        mon_b = exp_q.pop_front();
        chk("beat_data", data, mon_b.d);
        chk("beat_pos", pos, mon_b.p);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned acc;
    int busy;
    int w;

    // Command table: cmd, prints?, printed value, status once idle.
    t(4'd1, 1, 1, 2'd2); t(4'd2, 1, 12, 2'd2); t(4'd3, 1, 123, 2'd2);
    t(4'd10, 0, 0, 2'd2); t(4'd3, 1, 3, 2'd2); t(4'd0, 1, 30, 2'd2);
    t(4'd14, 1, 153, 2'd2);
    t(4'd7, 1, 7, 2'd2); t(4'd15, 1, 0, 2'd2); t(4'd15, 1, 0, 2'd2);
    t(4'd14, 0, 0, 2'd2);
    t(4'd11, 0, 0, 2'd2); t(4'd9, 1, 9, 2'd2); t(4'd14, 0, 0, 2'd0);
    t(4'd5, 0, 0, 2'd0); t(4'd13, 1, 0, 2'd2);
    acc = 0;
    for (int i = 0; i < 4; i++) begin acc = acc * 10 + 9; t(4'd9, 1, acc, 2'd2); end
    t(4'd12, 0, 0, 2'd2);
    acc = 0;
    for (int i = 0; i < 4; i++) begin acc = acc * 10 + 9; t(4'd9, 1, acc, 2'd2); end
    t(4'd14, 1, 99980001, 2'd2);
    acc = 0;
    for (int i = 0; i < 8; i++) begin acc = acc * 10 + 9; t(4'd9, 1, acc, 2'd2); end
    t(4'd5, 0, 0, 2'd2);
    t(4'd10, 0, 0, 2'd2); t(4'd1, 1, 1, 2'd2); t(4'd14, 0, 0, 2'd0);
    t(4'd15, 0, 0, 2'd0); t(4'd13, 1, 0, 2'd2); t(4'd15, 1, 0, 2'd2);
    t(4'd2, 1, 2, 2'd2); t(4'd10, 0, 0, 2'd2); t(4'd3, 1, 3, 2'd2);
`ifdef CALC_CHAIN_EN
    t(4'd10, 1, 5, 2'd2); t(4'd4, 1, 4, 2'd2); t(4'd14, 1, 9, 2'd2);
`else
    t(4'd10, 0, 0, 2'd0); t(4'd4, 0, 0, 2'd0); t(4'd14, 0, 0, 2'd0);
    t(4'd13, 1, 0, 2'd2);
`endif

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_status", status, 64'd2);
    chk("rst_data", data, 64'd0);
    chk("rst_pos", pos, 64'd0);
    chk("rst_valid", {63'd0, data_valid}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].pr) push_val(vecs[i].val);
      send(vecs[i].c);
      wait_idle();
      chk($sformatf("vec%0d_status", i), status, {62'd0, vecs[i].st});
    end

    // Add timing: one CALC cycle then beats immediately.
    push_val(1); send(4'd1); wait_idle();
    send(4'd10);
    push_val(2); send(4'd2); wait_idle();
    push_val(3);
    @(negedge clock);
    cmd = 4'd14; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    @(negedge clock);
    chk("add_calc_status", status, 64'd1);
    chk("add_calc_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clock);
    chk("add_beat0_status", status, 64'd3);
    chk("add_beat0_valid", {63'd0, data_valid}, 64'd1);
    wait_idle();

    // Multiply timing: busy for WIDTH+1 cycles, beats follow directly.
    send(4'd12);
    push_val(4); send(4'd4); wait_idle();
    push_val(12);
    @(negedge clock);
    cmd = 4'd14; cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    busy = 0; w = 0;
    @(negedge clock);
    while (status == 2'b01 && w < 100) begin
      busy++;
      @(negedge clock);
      w++;
    end
    chk("mul_busy_cycles", busy, WIDTH + 1);
    chk("mul_first_beat", {63'd0, data_valid}, 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of a print.
    push_val(5); send(4'd5); wait_idle();
    mon_en = 1'b0;
    send(4'd6);
    repeat (3) @(negedge clock);
    chk("midprint_status", status, 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("arst_status", status, 64'd2);
    chk("arst_valid", {63'd0, data_valid}, 64'd0);
    chk("arst_data", data, 64'd0);
    chk("arst_pos", pos, 64'd0);
    chk("arst_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
    push_val(7); send(4'd7); wait_idle();
    push_val(78); send(4'd8); wait_idle();
    chk("post_rst_status", status, 64'd2);

    chk("exp_queue_drained", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
